// File: rtl/sha3_pkg.sv
// Shared SHA3 digest definitions: mode encoding, lane geometry and the
// mapping from digest size to the number of output lanes.
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        SHA3_224 = 2'b00,
        SHA3_256 = 2'b01,
        SHA3_384 = 2'b10,
        SHA3_512 = 2'b11
    } sha3_mode_e;

    function automatic logic [3:0] lane_count(input sha3_mode_e m);
        case (m)
            SHA3_384: return 4'd6;
            SHA3_512: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/sha3_digest_packer.sv
// Captures the leading lanes of a final Keccak state and pushes the digest
// lane by lane into a result FIFO, stalling while the FIFO is full.
module sha3_digest_packer #(
    parameter int WIDTH     = 64,
    parameter int MAX_LANES = sha3_pkg::MAX_LANES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1599:0]     state_in,
    input  logic              state_valid,
    output logic              state_ready,
    input  logic [1:0]        mode,
    input  logic              clear,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WIDTH-1:0]  fifo_data,
    output logic              busy,
    output logic              done
);

    import sha3_pkg::LANE_W;
    import sha3_pkg::sha3_mode_e;
    import sha3_pkg::SHA3_224;
    import sha3_pkg::lane_count;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lanes_q [MAX_LANES];
    logic [WIDTH-1:0] lanes_d [MAX_LANES];
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last;
    sha3_mode_e       mode_sel;

    // Lanes beyond the largest digest never leave the block.
    logic unused_state_hi;
    assign unused_state_hi = ^state_in[1599:LANE_W*MAX_LANES];

    assign mode_sel    = sha3_mode_e'(mode);
    assign state_ready = (state_q == IDLE);
    assign busy        = (state_q == EMIT) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign fifo_wr_en  = (state_q == EMIT) && !fifo_full && !clear;
    assign fifo_data   = lanes_q[idx_q];
    assign last        = (({1'b0, idx_q} + 4'd1) == cnt_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_valid) begin
                        state_d = EMIT;
                        idx_d   = '0;
                        cnt_d   = lane_count(mode_sel);
                        for (int unsigned i = 0; i < MAX_LANES; i++) begin
                            lanes_d[i] = state_in[LANE_W*i +: WIDTH];
                        end
                        if (mode_sel == SHA3_224) begin
                            lanes_d[3][WIDTH-1:32] = '0;
                        end
                    end
                end
                EMIT: begin
                    // Index parks on the final lane so it never wraps.
                    if (!fifo_full) begin
                        if (last) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < MAX_LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: tb/tb_sha3_digest_packer.sv
// Directed bench for sha3_digest_packer with a lane scoreboard and a
// modelled depth-4 result FIFO.
module tb_sha3_digest_packer;

    logic          clk;
    logic          reset_n;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          state_ready;
    logic [1:0]    mode;
    logic          clear;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [63:0]   fifo_data;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_q [$];
    logic [63:0] lv [8];
    int push_cnt     = 0;
    int done_cnt     = 0;
    int pushes_total = 0;
    int reads_total  = 0;
    logic use_fifo   = 1'b0;

    assign fifo_full = use_fifo && ((pushes_total - reads_total) >= 4);

    sha3_digest_packer #(.WIDTH(64), .MAX_LANES(8)) dut (
        .clk(clk), .reset_n(reset_n), .state_in(state_in),
        .state_valid(state_valid), .state_ready(state_ready), .mode(mode),
        .clear(clear), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every push observed mid-cycle must match the next expected lane.
    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (fifo_wr_en) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected push", 64'(fifo_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("lane data", fifo_data, e);
            end
        end
        if (done) done_cnt++;
    end

    // A push seen mid-cycle is committed to the FIFO model by the next edge.
    always @(posedge clk) begin
        #1;
        pushes_total = push_cnt;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [1:0] m);
        logic [1599:0] s;
        int n;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) s[64*i +: 64] = lv[i];
        n = (m == 2'b10) ? 6 : (m == 2'b11) ? 8 : 4;
        for (int i = 0; i < n; i++) begin
            if (m == 2'b00 && i == 3) exp_q.push_back(lv[i] & 64'h0000_0000_FFFF_FFFF);
            else                      exp_q.push_back(lv[i]);
        end
        state_in    = s;
        mode        = m;
        state_valid = 1'b1;
        step();
        state_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            if (use_fifo && (pushes_total - reads_total) > 0) reads_total++;
            step();
        end
        chk("done reached", 64'(done), 64'd1);
        step();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 8; i++) lv[i] = {$urandom, $urandom};
    endtask

    initial begin
        int p0, d0;
        reset_n     = 1'b1;
        state_in    = '0;
        state_valid = 1'b0;
        mode        = 2'b00;
        clear       = 1'b0;
        #1 reset_n  = 1'b0;
        #1;
        chk("reset state_ready", 64'(state_ready), 64'd1);
        chk("reset busy",        64'(busy),        64'd0);
        chk("reset done",        64'(done),        64'd0);
        chk("reset fifo_wr_en",  64'(fifo_wr_en),  64'd0);
        chk("reset fifo_data",   fifo_data,        64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // SHA3-256 with exact push/done timing
        for (int i = 0; i < 8; i++) lv[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        p0 = push_cnt; d0 = done_cnt;
        load(2'b01);
        for (int k = 0; k < 4; k++) begin
            chk("256 push cycle", 64'(fifo_wr_en), 64'd1);
            chk("256 not ready",  64'(state_ready), 64'd0);
            step();
        end
        chk("256 done cycle", 64'(done), 64'd1);
        chk("256 wr_en in done", 64'(fifo_wr_en), 64'd0);
        chk("256 busy in done", 64'(busy), 64'd1);
        step();
        chk("256 done one cycle", 64'(done), 64'd0);
        chk("256 back to idle", 64'(state_ready), 64'd1);
        chk("256 push count", 64'(push_cnt - p0), 64'd4);
        chk("256 done count", 64'(done_cnt - d0), 64'd1);

        // SHA3-224 truncation of lane 3
        rand_lanes();
        lv[3] = 64'hDEAD_BEEF_CAFE_F00D;
        p0 = push_cnt;
        load(2'b00);
        wait_done();
        chk("224 push count", 64'(push_cnt - p0), 64'd4);
        chk("224 scoreboard empty", 64'(exp_q.size()), 64'd0);

        // SHA3-512 into a depth-4 FIFO with stalls
        rand_lanes();
        reads_total = pushes_total;
        use_fifo = 1'b1;
        p0 = push_cnt; d0 = done_cnt;
        load(2'b11);
        for (int k = 0; k < 4; k++) step();
        chk("512 pushes before full", 64'(push_cnt - p0), 64'd4);
        chk("512 fifo full", 64'(fifo_full), 64'd1);
        chk("512 stalled wr_en", 64'(fifo_wr_en), 64'd0);
        chk("512 held data", fifo_data, lv[4]);
        step();
        chk("512 held data later", fifo_data, lv[4]);
        chk("512 still stalled", 64'(fifo_wr_en), 64'd0);
        reads_total++;
        step();
        reads_total++;
        step();
        chk("512 resumed pushes", 64'(push_cnt - p0), 64'd6);
        wait_done();
        use_fifo = 1'b0;
        chk("512 push count", 64'(push_cnt - p0), 64'd8);
        chk("512 done count", 64'(done_cnt - d0), 64'd1);
        chk("512 scoreboard empty", 64'(exp_q.size()), 64'd0);

        // state_valid during EMIT must be ignored
        rand_lanes();
        p0 = push_cnt;
        load(2'b01);
        state_in    = ~state_in;
        mode        = 2'b11;
        state_valid = 1'b1;
        step();
        step();
        state_valid = 1'b0;
        wait_done();
        chk("busy valid push count", 64'(push_cnt - p0), 64'd4);
        chk("busy valid scoreboard empty", 64'(exp_q.size()), 64'd0);

        // clear after the second push of SHA3-384
        rand_lanes();
        p0 = push_cnt; d0 = done_cnt;
        load(2'b10);
        step();
        step();
        clear = 1'b1;
        #1;
        chk("clear blocks wr_en", 64'(fifo_wr_en), 64'd0);
        step();
        clear = 1'b0;
        chk("clear ready", 64'(state_ready), 64'd1);
        chk("clear not busy", 64'(busy), 64'd0);
        chk("clear leftover lanes", 64'(exp_q.size()), 64'd4);
        exp_q.delete();
        for (int k = 0; k < 4; k++) step();
        chk("clear push count", 64'(push_cnt - p0), 64'd2);
        chk("clear no done", 64'(done_cnt - d0), 64'd0);

        // clear with simultaneous state_valid in IDLE
        clear       = 1'b1;
        state_valid = 1'b1;
        step();
        clear       = 1'b0;
        state_valid = 1'b0;
        chk("clear+valid idle", 64'(state_ready), 64'd1);
        chk("clear+valid not busy", 64'(busy), 64'd0);

        rand_lanes();
        load(2'b01);
        wait_done();
        chk("after clear scoreboard empty", 64'(exp_q.size()), 64'd0);

        // reset pulse mid-EMIT
        rand_lanes();
        p0 = push_cnt; d0 = done_cnt;
        load(2'b11);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("rst mid wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst mid ready", 64'(state_ready), 64'd1);
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid data", fifo_data, 64'd0);
        chk("rst leftover lanes", 64'(exp_q.size()), 64'd6);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("rst push count", 64'(push_cnt - p0), 64'd2);
        chk("rst no done", 64'(done_cnt - d0), 64'd0);

        rand_lanes();
        lv[3] = 64'h0123_4567_89AB_CDEF;
        p0 = push_cnt;
        load(2'b00);
        wait_done();
        chk("after rst push count", 64'(push_cnt - p0), 64'd4);
        chk("after rst scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
